// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the ALU execute stage: datapath width and select codes.
package alu_exec_stage_pkg;

  localparam int unsigned DATA_W = 32;

  // Function select {S2,S1,S0}; S2=0 arithmetic (uses carry-in), S2=1 logic.
  typedef enum logic [2:0] {
    SEL_XFER = 3'b000,  // F = A + Ci
    SEL_ADD  = 3'b001,  // F = A + B + Ci
    SEL_SUB  = 3'b010,  // F = A + ~B + Ci (A - B when Ci = 1)
    SEL_DEC  = 3'b011,  // F = A - 1 + Ci
    SEL_AND  = 3'b100,  // F = A & B
    SEL_OR   = 3'b101,  // F = A | B
    SEL_XOR  = 3'b110,  // F = A ^ B
    SEL_NOT  = 3'b111   // F = ~A
  } alu_sel_e;

endpackage

// File: rtl/alu_32_bit.sv
// Combinational 32-bit ALU: four arithmetic functions with carry, four logic functions.
module alu_32_bit
  import alu_exec_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  input  logic              ci,
  output logic [DATA_W-1:0] f,
  output logic              co
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] ci_ext;

  assign ci_ext = {{DATA_W{1'b0}}, ci};

  // Function decode; carry-out is only meaningful for arithmetic codes, 0 otherwise.
  always_comb begin
    sum = '0;
    f   = '0;
    co  = 1'b0;
    case (alu_sel_e'(sel))
      SEL_XFER: sum = {1'b0, a} + ci_ext;
      SEL_ADD:  sum = {1'b0, a} + {1'b0, b} + ci_ext;
      SEL_SUB:  sum = {1'b0, a} + {1'b0, ~b} + ci_ext;
      SEL_DEC:  sum = {1'b0, a} + {1'b0, {DATA_W{1'b1}}} + ci_ext;
      default:  sum = '0;
    endcase
    case (alu_sel_e'(sel))
      SEL_AND: f = a & b;
      SEL_OR:  f = a | b;
      SEL_XOR: f = a ^ b;
      SEL_NOT: f = ~a;
      default: begin
        f  = sum[DATA_W-1:0];
        co = sum[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage valid/ready ALU execute stage: stage 1 holds operands, stage 2 holds
// the registered ALU result and flags. Full throughput with backpressure.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_sel,
  input  logic              in_ci,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic              out_co,
  output logic              out_zero,
  output logic              out_neg,
  output logic [CNT_W-1:0]  op_count
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [2:0]        s1_sel;
  logic              s1_ci;

  logic              s2_valid;
  logic              s2_load;
  logic              in_fire;
  logic              out_fire;

  logic [DATA_W-1:0] alu_f;
  logic              alu_co;

  alu_32_bit u_alu (
    .a   (s1_a),
    .b   (s1_b),
    .sel (s1_sel),
    .ci  (s1_ci),
    .f   (alu_f),
    .co  (alu_co)
  );

  // Handshake: stage 2 advances when empty or draining; stage 1 accepts when
  // empty or handing its operation forward. Reset blocks acceptance.
  always_comb begin
    out_fire = s2_valid && out_ready;
    s2_load  = !s2_valid || out_ready;
    in_ready = !rst && (!s1_valid || s2_load);
    in_fire  = in_valid && in_ready;
  end

  // Stage 1 operand register; a new operation replaces one moving on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
      s1_ci    <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_sel   <= in_sel;
      s1_ci    <= in_ci;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 result register; data only changes when a valid operation arrives,
  // so outputs stay put under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_f    <= '0;
      out_co   <= 1'b0;
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_f    <= alu_f;
        out_co   <= alu_co;
        out_zero <= (alu_f == '0);
        out_neg  <= alu_f[DATA_W-1];
      end
    end
  end

  assign out_valid = s2_valid;

  // Completed-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and randomized checks of alu_exec_stage against hand values and a reference ALU.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_sel;
  logic        in_ci;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic        out_co;
  logic        out_zero;
  logic        out_neg;
  logic [15:0] op_count;

  logic        w2_in_ready;
  logic        w2_out_valid;
  logic [31:0] w2_out_f;
  logic        w2_out_co;
  logic        w2_out_zero;
  logic        w2_out_neg;
  logic [1:0]  w2_op_count;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_ci(in_ci),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .out_co(out_co), .out_zero(out_zero), .out_neg(out_neg), .op_count(op_count)
  );

  alu_exec_stage #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w2_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_ci(in_ci),
    .out_valid(w2_out_valid), .out_ready(out_ready), .out_f(w2_out_f),
    .out_co(w2_out_co), .out_zero(w2_out_zero), .out_neg(w2_out_neg),
    .op_count(w2_op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic ci);
    in_valid = v; in_a = a; in_b = b; in_sel = sel; in_ci = ci;
  endtask

  // Reference ALU, result packed as {neg, zero, co, f}.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] sel, input logic ci);
    logic [32:0] s;
    logic [31:0] f;
    logic        co;
    s = '0;
    case (sel)
      3'd0: s = {1'b0, a} + 33'(ci);
      3'd1: s = {1'b0, a} + {1'b0, b} + 33'(ci);
      3'd2: s = {1'b0, a} - {1'b0, b} - 33'(!ci) + 33'h1_0000_0000;
      3'd3: s = {1'b0, a} + 33'h0_FFFF_FFFF + 33'(ci);
      default: s = '0;
    endcase
    f = s[31:0];
    co = s[32];
    case (sel)
      3'd4: begin f = a & b; co = 1'b0; end
      3'd5: begin f = a | b; co = 1'b0; end
      3'd6: begin f = a ^ b; co = 1'b0; end
      3'd7: begin f = ~a;    co = 1'b0; end
      default: ;
    endcase
    return {f[31], (f == 32'd0), co, f};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic [1:0]  wrap_seq [5];
    logic        fire;
    logic        stall_prev;
    logic [31:0] f_prev;
    logic [31:0] cnt_model;
    int unsigned k;

    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, '0, '0, 3'b000, 1'b0);

    // Reset state
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_out_f", out_f, 32'd0);
    chk("rst_flags", {28'd0, out_co, out_zero, out_neg, 1'b0}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Subtract, 2-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h8101_0101, 32'h6161_6161, 3'b010, 1'b1);
    step();
    in_valid = 1'b0;
    chk("sub_lat1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_f", out_f, 32'h1F9F_9FA0);
    chk("sub_flags", {29'd0, out_co, out_zero, out_neg}, 32'b100);
    step();
    chk("sub_count", {16'd0, op_count}, 32'd1);
    chk("sub_drained", {31'd0, out_valid}, 32'd0);

    // Zero then negative, back to back
    drive(1'b1, 32'h1234_5678, 32'h1234_5678, 3'b010, 1'b1);
    step();
    drive(1'b1, 32'h0, 32'h1, 3'b010, 1'b1);
    step();
    in_valid = 1'b0;
    chk("zero_f", out_f, 32'h0);
    chk("zero_flags", {28'd0, out_valid, out_co, out_zero, out_neg}, 32'b1110);
    step();
    chk("neg_f", out_f, 32'hFFFF_FFFF);
    chk("neg_flags", {28'd0, out_valid, out_co, out_zero, out_neg}, 32'b1001);
    step();
    chk("zn_count", {16'd0, op_count}, 32'd3);

    // Backpressure: three ops offered, two fit
    out_ready = 1'b0;
    drive(1'b1, 32'd5, 32'd7, 3'b001, 1'b0);
    step();
    drive(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 1'b0);
    step();
    drive(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 3'b110, 1'b0);
    #1;
    chk("bp_ready0", {31'd0, in_ready}, 32'd0);
    chk("bp_f_a", out_f, 32'd12);
    step();
    chk("bp_ready0_b", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_f", out_f, 32'd12);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_hold_f2", out_f, 32'd12);
    chk("bp_hold_count", {16'd0, op_count}, 32'd3);
    out_ready = 1'b1;
    #1;
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_f_b", out_f, 32'hF000_F000);
    chk("bp_neg_b", {31'd0, out_neg}, 32'd1);
    step();
    chk("bp_f_c", out_f, 32'h5555_5555);
    chk("bp_valid_c", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_count", {16'd0, op_count}, 32'd6);

    // Reset with two ops in flight
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 32'd3, 3'b010, 1'b1);
    step();
    drive(1'b1, 32'd20, 32'd4, 3'b010, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {16'd0, op_count}, 32'd0);
    chk("mid_rst_w2_count", {30'd0, w2_op_count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Counter wrap on the CNT_W=2 instance
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      if (c < 5) drive(1'b1, 32'(c), 32'd1, 3'b001, 1'b0);
      else in_valid = 1'b0;
      #1;
      fire = w2_out_valid && out_ready;
      step();
      if (fire) begin
        chk("wrap_count", {30'd0, w2_op_count}, {30'd0, wrap_seq[k]});
        k++;
      end
    end
    in_valid = 1'b0;
    chk("wrap_all_seen", k, 32'd5);
    chk("wrap_main_count", {16'd0, op_count}, 32'd5);

    // Random stress against the reference model
    stall_prev = 1'b0;
    f_prev = '0;
    cnt_model = 32'd5;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 9) < 7);
      in_a = $urandom();
      in_b = ($urandom_range(0, 7) == 0) ? in_a : $urandom();
      in_sel = 3'($urandom_range(0, 7));
      in_ci = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (stall_prev) chk("rnd_hold_f", out_f, f_prev);
      chk("rnd_in_ready", {31'd0, in_ready},
          {31'd0, (exp_q.size() < 2) || out_ready});
      chk("rnd_w2_in_ready", {31'd0, w2_in_ready}, {31'd0, in_ready});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 32'd1, 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("rnd_f", out_f, e[31:0]);
          chk("rnd_flags", {29'd0, out_neg, out_zero, out_co}, {29'd0, e[35:32]});
          chk("rnd_w2_f", w2_out_f, e[31:0]);
          chk("rnd_w2_flags", {29'd0, w2_out_neg, w2_out_zero, w2_out_co}, {29'd0, e[35:32]});
          cnt_model++;
        end
      end
      stall_prev = out_valid && !out_ready;
      f_prev = out_f;
      if (in_valid && in_ready) exp_q.push_back(ref_alu(in_a, in_b, in_sel, in_ci));
    end

    // Drain what remains, bounded
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("drain_f", out_f, e[31:0]);
        cnt_model++;
      end
      step();
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("rnd_count", {16'd0, op_count}, {16'd0, cnt_model[15:0]});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
